// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/writeback for
// lw, sw, R-type, I-type ALU, beq and jal, and drives the datapath controls.
// Memory accesses use a req/ready handshake with an optional timeout that
// parks the FSM in HALT with a sticky bus_err.
module multicycle_control #(
  parameter int ALU_W    = 3,
  parameter int MAX_WAIT = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op_code,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [2:0]       imm_type,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal,
  output logic             bus_err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_HALT
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(3'b000);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(3'b001);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(3'b010);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3'b011);
  localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3'b101);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;

  // Count value at which one more un-ready cycle means a timeout.
  localparam int              LIM_INT = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(LIM_INT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
  logic             req_int;
  logic             timeout;
  logic             unused_func7;

  // Only func7[5] distinguishes sub from add in the supported subset.
  assign unused_func7 = ^{func7[6], func7[4:0]};

  function automatic logic [ALU_W-1:0] alu_dec(input logic [2:0] f3, input logic is_sub);
    logic [ALU_W-1:0] code;
    case (f3)
      3'b000:  code = is_sub ? ALU_SUB : ALU_ADD;
      3'b111:  code = ALU_AND;
      3'b110:  code = ALU_OR;
      3'b010:  code = ALU_SLT;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Request is raised by the memory-access states, independent of reset gating.
  assign req_int = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);

  // A ready arriving in the last allowed cycle takes precedence over timeout.
  assign timeout = (MAX_WAIT != 0) && req_int && !mem_ready && (cnt_q == WAIT_LIM);

  // Next-state selection; a timeout overrides the normal sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_MEM_WB:    state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_HALT;
  end

  // State, wait counter and sticky bus error; the counter restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= '0;
      else if (req_int && !mem_ready)
        cnt_q <= cnt_q + 1'b1;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  // Output decode from the current state; everything is forced low while in reset.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    imm_type    = IMM_I;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    bus_err     = bus_err_q;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_type  = IMM_B;
          illegal   = !(op_code inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_type  = (op_code == OP_LW) ? IMM_I : IMM_S;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_MEM_WB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b00;
          alu_control = alu_dec(func3, func7[5]);
        end
        S_EXEC_I: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          imm_type    = IMM_I;
          alu_control = alu_dec(func3, 1'b0);
        end
        S_ALU_WB: begin
          result_src = 2'b00;
          reg_write  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b00;
          alu_control = ALU_SUB;
          pc_write    = zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// the FSM and compares the full control vector in every cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_code;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [2:0] imm_type;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic       illegal, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_control #(.ALU_W(3), .MAX_WAIT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .imm_type(imm_type), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
    .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Field order: req wr adr irw pcw rw imm[3] sa[2] sb[2] rs[2] alu[3] ill be
  logic [19:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_type,
                alu_src_a, alu_src_b, result_src, alu_control, illegal, bus_err};

  function automatic logic [19:0] pk(input logic req, wr, adr, irw, pcw, rw,
                                     input logic [2:0] imm, input logic [1:0] sa, sb, rs,
                                     input logic [2:0] alu, input logic ill, be);
    return {req, wr, adr, irw, pcw, rw, imm, sa, sb, rs, alu, ill, be};
  endfunction

  // Expected vectors for the fixed states.
  function automatic logic [19:0] e_fetch(input logic r);
    return pk(1,0,0,r,r,0,3'b000,2'b00,2'b10,2'b10,3'b000,0,0);
  endfunction
  localparam logic [19:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'b010,2'b01,2'b01,2'b00,3'b000,1'b0,1'b0};
  localparam logic [19:0] E_ALU_WB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'b000,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0};

  // Advance to mid-cycle, well away from the rising edge.
  task automatic clk_step();
    @(posedge clk);
    #3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op_code = 7'b0000011; func3 = 3'b000; func7 = 7'b0;
    zero = 1'b0; mem_ready = 1'b0;
    clk_step(); clk_step();
    n_checks++;
    if (obs !== 20'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 20'h0);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (obs !== e_fetch(1'b0)) begin
      n_fail++; $display("FAIL reset_to_fetch: got %b expected %b", obs, e_fetch(1'b0));
    end
  endtask

  task automatic test_lw();
    logic [19:0] exp_v [5];
    exp_v[0] = e_fetch(1'b1);
    exp_v[1] = E_DECODE;
    exp_v[2] = pk(0,0,0,0,0,0,3'b000,2'b10,2'b01,2'b00,3'b000,0,0);
    exp_v[3] = pk(1,0,1,0,0,0,3'b000,2'b00,2'b00,2'b00,3'b000,0,0);
    exp_v[4] = pk(0,0,0,0,0,1,3'b000,2'b00,2'b00,2'b01,3'b000,0,0);
    op_code = 7'b0000011; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin clk_step(); #1; end
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL lw_cycle%0d: got %b expected %b", i + 1, obs, exp_v[i]);
      end
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== e_fetch(1'b1)) begin
      n_fail++; $display("FAIL lw_back_to_fetch: got %b expected %b", obs, e_fetch(1'b1));
    end
  endtask

  task automatic test_sw_wait();
    logic [19:0] e_wr;
    e_wr = pk(1,1,1,0,0,0,3'b000,2'b00,2'b00,2'b00,3'b000,0,0);
    op_code = 7'b0100011; mem_ready = 1'b1;
    clk_step(); #1;
    n_checks++;
    if (obs !== E_DECODE) begin
      n_fail++; $display("FAIL sw_decode: got %b expected %b", obs, E_DECODE);
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== pk(0,0,0,0,0,0,3'b001,2'b10,2'b01,2'b00,3'b000,0,0)) begin
      n_fail++; $display("FAIL sw_mem_addr: got %b expected imm_type 001 sa 10 sb 01", obs);
    end
    // Three un-ready cycles, then ready in the fourth (last cycle before timeout).
    for (int i = 0; i < 4; i++) begin
      clk_step();
      mem_ready = (i == 3);
      #1;
      n_checks++;
      if (obs !== e_wr) begin
        n_fail++; $display("FAIL sw_write_cycle%0d: got %b expected %b", i + 1, obs, e_wr);
      end
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== e_fetch(1'b1)) begin
      n_fail++; $display("FAIL sw_back_to_fetch: got %b expected %b", obs, e_fetch(1'b1));
    end
  endtask

  task automatic run_alu(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [2:0] exp_alu,
                         input logic [1:0] exp_sb);
    logic [19:0] e_ex;
    e_ex = pk(0,0,0,0,0,0,3'b000,2'b10,exp_sb,2'b00,exp_alu,0,0);
    op_code = op; func3 = f3; func7 = f7; mem_ready = 1'b1;
    clk_step(); clk_step(); #1;
    n_checks++;
    if (obs !== e_ex) begin
      n_fail++; $display("FAIL %s_exec: got %b expected %b", nm, obs, e_ex);
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== E_ALU_WB) begin
      n_fail++; $display("FAIL %s_wb: got %b expected %b", nm, obs, E_ALU_WB);
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== e_fetch(1'b1)) begin
      n_fail++; $display("FAIL %s_fetch: got %b expected %b", nm, obs, e_fetch(1'b1));
    end
  endtask

  task automatic test_alu_decode();
    run_alu("r_sub", 7'b0110011, 3'b000, 7'b0100000, 3'b001, 2'b00);
    run_alu("r_add", 7'b0110011, 3'b000, 7'b0000000, 3'b000, 2'b00);
    run_alu("i_and", 7'b0010011, 3'b111, 7'b0000000, 3'b010, 2'b01);
    run_alu("i_nosub", 7'b0010011, 3'b000, 7'b0100000, 3'b000, 2'b01);
    run_alu("r_or", 7'b0110011, 3'b110, 7'b0000000, 3'b011, 2'b00);
    run_alu("r_slt", 7'b0110011, 3'b010, 7'b0000000, 3'b101, 2'b00);
    run_alu("i_other", 7'b0010011, 3'b100, 7'b0000000, 3'b000, 2'b01);
  endtask

  task automatic test_branch(input logic z);
    op_code = 7'b1100011; mem_ready = 1'b1; zero = z;
    clk_step(); clk_step(); #1;
    n_checks++;
    if (obs !== pk(0,0,0,0,z,0,3'b000,2'b10,2'b00,2'b00,3'b001,0,0)) begin
      n_fail++; $display("FAIL beq_zero%0d: got %b expected pc_write %0d sub", z, obs, z);
    end
    zero = ~z;
    #1;
    n_checks++;
    if (pc_write !== ~z) begin
      n_fail++; $display("FAIL beq_zero_comb: got pc_write %b expected %b", pc_write, ~z);
    end
    zero = z;
    clk_step(); #1;
    n_checks++;
    if (obs !== e_fetch(1'b1)) begin
      n_fail++; $display("FAIL beq_fetch%0d: got %b expected %b", z, obs, e_fetch(1'b1));
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    op_code = 7'b1101111; mem_ready = 1'b1;
    clk_step(); clk_step(); #1;
    n_checks++;
    if (obs !== pk(0,0,0,0,1,1,3'b000,2'b01,2'b10,2'b00,3'b000,0,0)) begin
      n_fail++; $display("FAIL jal: got %b expected pcw rw sa 01 sb 10", obs);
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== e_fetch(1'b1)) begin
      n_fail++; $display("FAIL jal_fetch: got %b expected %b", obs, e_fetch(1'b1));
    end
  endtask

  task automatic test_illegal();
    op_code = 7'b1111111; mem_ready = 1'b1;
    clk_step(); #1;
    n_checks++;
    if (obs !== (E_DECODE | 20'b10)) begin
      n_fail++; $display("FAIL illegal_pulse: got %b expected %b", obs, E_DECODE | 20'b10);
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== e_fetch(1'b1)) begin
      n_fail++; $display("FAIL illegal_next: got %b expected %b", obs, e_fetch(1'b1));
    end
  endtask

  task automatic test_reset_mid_access();
    op_code = 7'b0000011; mem_ready = 1'b1;
    clk_step(); clk_step(); clk_step();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b1 || adr_src !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_read: got req %b adr %b expected 1 1", mem_req, adr_src);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 20'h0) begin
      n_fail++; $display("FAIL midrst_async: got %b expected %b", obs, 20'h0);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (obs !== e_fetch(1'b0)) begin
      n_fail++; $display("FAIL midrst_fetch: got %b expected %b", obs, e_fetch(1'b0));
    end
  endtask

  task automatic test_timeout();
    // Already in a fresh FETCH with mem_ready low.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) clk_step();
      #1;
      n_checks++;
      if (obs !== e_fetch(1'b0)) begin
        n_fail++; $display("FAIL timeout_wait%0d: got %b expected %b", i + 1, obs, e_fetch(1'b0));
      end
    end
    clk_step(); #1;
    n_checks++;
    if (obs !== 20'h1) begin
      n_fail++; $display("FAIL timeout_halt: got %b expected %b", obs, 20'h1);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_step(); #1;
      n_checks++;
      if (obs !== 20'h1) begin
        n_fail++; $display("FAIL halt_sticky%0d: got %b expected %b", i, obs, 20'h1);
      end
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 20'h0) begin
      n_fail++; $display("FAIL halt_reset: got %b expected %b", obs, 20'h0);
    end
    clk_step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (obs !== e_fetch(1'b1)) begin
      n_fail++; $display("FAIL halt_restart: got %b expected %b", obs, e_fetch(1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu_decode();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jal();
    test_illegal();
    test_reset_mid_access();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
